// File: rtl/wsc_unlock_host.sv
// Console-side unlock handshake for the Bandai 2003 cartridge: drives the 5Ah/A5h address
// sequence, receives the 18-bit serial response and raises UNLOCK on a match. Macro: SI_SYNC_EN.
module wsc_unlock_host #(
  parameter logic [7:0]  ACK_ADDR  = 8'h5A,
  parameter logic [7:0]  NAK_ADDR  = 8'hA5,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF,
  parameter logic [15:0] EXPECT    = 16'h28A0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic [7:0]  addr_o,
  input  logic        si_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        unlock_o,
  output logic [15:0] data_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    IDLE, SEND_ACK, SEND_NAK, WAIT_START, SHIFT, STOP, FIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          unlock_q, unlock_d;
  logic [15:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          si_s;
  logic          accept_c;

`ifdef SI_SYNC_EN
  // Two-flop synchronizer; resets to the pulled-up idle level.
  logic [1:0] si_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) si_sync_q <= 2'b11;
    else        si_sync_q <= {si_sync_q[0], si_i};
  end
  assign si_s = si_sync_q[1];
`else
  assign si_s = si_i;
`endif

  assign accept_c = start_i && !unlock_q && ((state_q == IDLE) || (state_q == FIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= IDLE_ADDR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unlock_q <= 1'b0;
      data_q   <= 16'hFFFF;
      tmo_q    <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      unlock_q <= unlock_d;
      data_q   <= data_d;
      tmo_q    <= tmo_d;
      bit_q    <= bit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    unlock_d = unlock_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    bit_d    = bit_q;
    if (accept_c) begin
      state_d = SEND_ACK;
      addr_d  = ACK_ADDR;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SEND_ACK: begin
          state_d = SEND_NAK;
          addr_d  = NAK_ADDR;
        end
        SEND_NAK: begin
          state_d = WAIT_START;
          addr_d  = IDLE_ADDR;
          tmo_d   = '0;
        end
        WAIT_START: begin
          if (!si_s) begin
            state_d = SHIFT;
            bit_d   = '0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = FIN;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        SHIFT: begin
          data_d = {si_s, data_q[15:1]};
          bit_d  = bit_q + BW'(1);
          if (bit_q == BW'(15)) state_d = STOP;
        end
        STOP: begin
          if (si_s) err_d = 1'b1;
          state_d = FIN;
        end
        FIN: begin
          // Any earlier error (timeout, framing) already blocks the unlock.
          done_d = 1'b1;
          busy_d = 1'b0;
          if (!err_q && (data_q == EXPECT)) unlock_d = 1'b1;
          else                              err_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign addr_o   = addr_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign unlock_o = unlock_q;
  assign data_o   = data_q;

endmodule

// File: tb/tb_wsc_unlock_host.sv
// Bench for wsc_unlock_host: directed handshake cases plus randomized responses vs. a frame-level model.
`timescale 1ns/1ps
module tb_wsc_unlock_host;

  localparam logic [15:0] EXPECT  = 16'h28A0;
  localparam int          TIMEOUT = 16;
`ifdef SI_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        si_i = 1'b1;
  logic [7:0]  addr_o;
  logic        busy_o, done_o, err_o, unlock_o;
  logic [15:0] data_o;

  int n_pass  = 0;
  int n_total = 0;

  logic        m_unlock;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  wsc_unlock_host #(
    .ACK_ADDR (8'h5A),
    .NAK_ADDR (8'hA5),
    .IDLE_ADDR(8'hFF),
    .EXPECT   (EXPECT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .addr_o  (addr_o),
    .si_i    (si_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .unlock_o(unlock_o),
    .data_o  (data_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "/addr"},   32'(addr_o),   32'hFF);
    chk({tag, "/busy"},   32'(busy_o),   32'h0);
    chk({tag, "/done"},   32'(done_o),   32'h0);
    chk({tag, "/err"},    32'(err_o),    32'h0);
    chk({tag, "/unlock"}, 32'(unlock_o), 32'h0);
    chk({tag, "/data"},   32'(data_o),   32'hFFFF);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset(tag);
    @(negedge clk);
    rst_n    = 1'b1;
    si_i     = 1'b1;
    start_i  = 1'b0;
    m_unlock = 1'b0;
    m_data   = 16'hFFFF;
  endtask

  // One START request with the cart answering frame {start 0, w LSB-first, stop_v};
  // tmo keeps SI high; abort_c >= 0 resets the host after that many frame cycles.
  task automatic run_txn(input logic [15:0] w, input logic stop_v, input bit tmo,
                         input int abort_c, input string tag);
    logic [17:0] frame;
    bit          ign;
    logic        exp_unlock, exp_err;
    frame = {stop_v, w, 1'b0};
    ign   = m_unlock;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    chk({tag, "/addr_t"},  32'(addr_o), ign ? 32'hFF : 32'h5A);
    chk({tag, "/busy_t"},  32'(busy_o), ign ? 32'h0 : 32'h1);
    @(negedge clk);
    chk({tag, "/addr_t1"}, 32'(addr_o), ign ? 32'hFF : 32'hA5);
    @(negedge clk);
    chk({tag, "/addr_t2"}, 32'(addr_o), 32'hFF);
    for (int c = 0; c <= TIMEOUT + 20 + LAT; c++) begin
      si_i    = tmo ? 1'b1 : ((c < 18) ? frame[c] : 1'($urandom));
      start_i = (c == 5);
      @(negedge clk);
      if (c == abort_c) begin
        pulse_reset({tag, "/abort"});
        return;
      end
      if (!ign) begin
        if (tmo && c == TIMEOUT - 1) chk({tag, "/done_pre"}, 32'(done_o), 32'h0);
        if (tmo && c == TIMEOUT)     chk({tag, "/done_at"},  32'(done_o), 32'h1);
        if (!tmo && c == 17 + LAT) begin
          chk({tag, "/done_pre"}, 32'(done_o), 32'h0);
          chk({tag, "/busy_pre"}, 32'(busy_o), 32'h1);
        end
        if (!tmo && c == 18 + LAT) begin
          chk({tag, "/done_at"}, 32'(done_o), 32'h1);
          chk({tag, "/busy_at"}, 32'(busy_o), 32'h0);
        end
      end
    end
    si_i    = 1'b1;
    start_i = 1'b0;
    if (ign) begin
      exp_unlock = 1'b1;
      exp_err    = 1'b0;
    end else if (tmo) begin
      exp_unlock = 1'b0;
      exp_err    = 1'b1;
    end else begin
      m_data     = w;
      exp_unlock = (stop_v == 1'b0) && (w == EXPECT);
      exp_err    = !exp_unlock;
    end
    m_unlock = exp_unlock;
    chk({tag, "/done"},   32'(done_o),   32'h1);
    chk({tag, "/busy"},   32'(busy_o),   32'h0);
    chk({tag, "/err"},    32'(err_o),    32'(exp_err));
    chk({tag, "/unlock"}, 32'(unlock_o), 32'(exp_unlock));
    chk({tag, "/data"},   32'(data_o),   32'(m_data));
    chk({tag, "/addr"},   32'(addr_o),   32'hFF);
  endtask

  initial begin
    logic [15:0] w;
    logic        sb;
    bit          tm;
    m_unlock = 1'b0;
    m_data   = 16'hFFFF;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    run_txn(EXPECT,   1'b0, 1'b0, -1, "t1_pass");
    run_txn(16'h1234, 1'b0, 1'b0, -1, "t5_ignored");
    pulse_reset("rst_after_pass");
    run_txn(16'h28A1, 1'b0, 1'b0, -1, "t2_mismatch");
    run_txn(16'h0000, 1'b0, 1'b1, -1, "t3_timeout");
    run_txn(EXPECT,   1'b1, 1'b0, -1, "t4_badstop");
    run_txn(16'hFFFF, 1'b1, 1'b0, -1, "glitch");
    run_txn(EXPECT,   1'b0, 1'b0, 8 + LAT, "t6_abort");
    run_txn(EXPECT,   1'b0, 1'b0, -1, "t6_fresh");
    pulse_reset("rst_before_rand");

    for (int i = 0; i < 10; i++) begin
      w  = ($urandom_range(0, 2) == 0) ? EXPECT : 16'($urandom);
      sb = ($urandom_range(0, 3) == 0);
      tm = ($urandom_range(0, 5) == 0);
      run_txn(w, sb, tm, -1, $sformatf("rand%0d", i));
      if (m_unlock) pulse_reset($sformatf("rand%0d_rst", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
